// File: rtl/riscv_retire_checker.sv
// rtl/riscv_retire_checker.sv - retirement checker: programmable PC checkpoints, store/result compare, loop bounds, hang detect
module riscv_retire_checker #(
   parameter int XLEN        = 32,
   parameter int NUM_CHECKS  = 64,
   parameter int IDX_W       = 6,
   parameter int CNT_W       = 16,
   parameter int HANG_CYCLES = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_we,
   input  logic [IDX_W-1:0]  cfg_idx,
   input  logic [1:0]        cfg_kind,
   input  logic [XLEN-1:0]   cfg_pc,
   input  logic [XLEN-1:0]   cfg_data,
   input  logic [XLEN-1:0]   cfg_mask,
   input  logic [XLEN-1:0]   cfg_adr,
   input  logic              start,
   input  logic [XLEN-1:0]   end_pc,
   input  logic [XLEN-1:0]   PC,
   input  logic [XLEN-1:0]   Result,
   input  logic [XLEN-1:0]   DataAdr,
   input  logic [XLEN-1:0]   WriteData,
   input  logic              MemWrite,
   output logic [1:0]        state,
   output logic [CNT_W-1:0]  pass_cnt,
   output logic [CNT_W-1:0]  fail_cnt,
   output logic [IDX_W:0]    seen_cnt,
   output logic              fail_valid,
   output logic [IDX_W-1:0]  fail_idx,
   output logic              hang
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, STUCK = 2'd3} stateT;

   localparam logic [15:0]      INIT_KEY = 16'hA5C3;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam int               HW       = $clog2(HANG_CYCLES + 1);

   localparam logic [1:0] K_RESULT = 2'd1;
   localparam logic [1:0] K_STORE  = 2'd2;
   localparam logic [1:0] K_LOOP   = 2'd3;

   stateT curState, nxtState;

   // checkpoint table; survives reset, qualified by tValid
   logic [1:0]      tKind [NUM_CHECKS];
   logic [XLEN-1:0] tPc   [NUM_CHECKS];
   logic [XLEN-1:0] tData [NUM_CHECKS];
   logic [XLEN-1:0] tMask [NUM_CHECKS];
   logic [XLEN-1:0] tAdr  [NUM_CHECKS];
   logic [NUM_CHECKS-1:0] tValid;
   logic [15:0]           initKey;

   logic [NUM_CHECKS-1:0] seenBits;
   logic [CNT_W-1:0]      hitCnt [NUM_CHECKS];
   logic [XLEN-1:0]       endPc;
   logic [HW-1:0]         hangCnt;

   // stage-1 retirement sample
   logic            s1Valid, s1MemWrite, s1Same;
   logic [XLEN-1:0] s1Pc, s1Result, s1Adr, s1WData;

   logic            tableWe;
   logic            hit;
   logic [IDX_W-1:0] hitIdx;
   logic            evalEn, resOk, storeOk, loopViol, isPass, isFail, hangHit, goStuck, goDone;
   logic [CNT_W-1:0] hitNext;
   logic [1:0]      hitKind;
   logic [XLEN-1:0] hitMask;

   assign tableWe = cfg_we && (curState == IDLE);
   assign evalEn  = (curState == RUN) && s1Valid;

   // register the core's retirement signals; only samples taken while running are evaluated
   always_ff @(posedge clk) begin
      if (reset) begin
         s1Valid    <= 1'b0;
         s1MemWrite <= 1'b0;
         s1Same     <= 1'b0;
         s1Pc       <= '0;
         s1Result   <= '0;
         s1Adr      <= '0;
         s1WData    <= '0;
      end else begin
         s1Valid    <= (curState == RUN);
         s1MemWrite <= MemWrite;
         s1Same     <= (PC == s1Pc);
         s1Pc       <= PC;
         s1Result   <= Result;
         s1Adr      <= DataAdr;
         s1WData    <= WriteData;
      end
   end

   // table contents: written in IDLE only, never reset
   always_ff @(posedge clk) begin
      if (!reset && tableWe) begin
         tKind[cfg_idx] <= cfg_kind;
         tPc[cfg_idx]   <= cfg_pc;
         tData[cfg_idx] <= cfg_data;
         tMask[cfg_idx] <= cfg_mask;
         tAdr[cfg_idx]  <= cfg_adr;
      end
   end

   // entry valid bits: cleared only by the first reset after power-up (key not yet planted)
   always_ff @(posedge clk) begin
      if (reset) begin
         if (initKey != INIT_KEY) begin
            tValid  <= '0;
            initKey <= INIT_KEY;
         end
      end else if (tableWe) begin
         tValid[cfg_idx] <= 1'b1;
      end
   end

   // lowest-index enabled entry whose PC matches the sampled PC
   always_comb begin
      hit    = 1'b0;
      hitIdx = '0;
      for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
         if (tValid[i] && tKind[i] != 2'd0 && tPc[i] == s1Pc) begin
            hit    = 1'b1;
            hitIdx = IDX_W'(i);
         end
      end
   end

   // evaluate the matched entry against the sample
   always_comb begin
      hitKind  = tKind[hitIdx];
      hitMask  = tMask[hitIdx];
      resOk    = (s1Result & hitMask) == (tData[hitIdx] & hitMask);
      storeOk  = s1MemWrite && (s1Adr == tAdr[hitIdx]) &&
                 ((s1WData & hitMask) == (tData[hitIdx] & hitMask));
      hitNext  = (hitCnt[hitIdx] == CNT_MAX) ? CNT_MAX : hitCnt[hitIdx] + CNT_W'(1);
      loopViol = (s1Result > tData[hitIdx]) || (hitNext > tAdr[hitIdx][CNT_W-1:0]);
      isPass   = evalEn && hit && ((hitKind == K_RESULT && resOk) || (hitKind == K_STORE && storeOk));
      isFail   = evalEn && hit && ((hitKind == K_RESULT && !resOk) ||
                                   (hitKind == K_STORE && !storeOk) ||
                                   (hitKind == K_LOOP && loopViol));
      hangHit  = evalEn && s1Same && (hangCnt == HW'(HANG_CYCLES - 1));
      goStuck  = hangHit || (isFail && hitKind == K_LOOP);
      goDone   = evalEn && (s1Pc == endPc);
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset) curState <= IDLE;
      else       curState <= nxtState;
   end

   // next-state logic; a stuck condition outranks reaching end_pc
   always_comb begin
      nxtState = curState;
      unique case (curState)
         IDLE:        if (start) nxtState = RUN;
         RUN:         if (goStuck) nxtState = STUCK;
                      else if (goDone) nxtState = DONE;
         DONE, STUCK: if (start) nxtState = RUN;
         default:     nxtState = IDLE;
      endcase
   end

   // counters, seen bits, per-entry hit counts, hang tracking and failure event
   always_ff @(posedge clk) begin
      if (reset) begin
         pass_cnt   <= '0;
         fail_cnt   <= '0;
         seen_cnt   <= '0;
         seenBits   <= '0;
         fail_valid <= 1'b0;
         fail_idx   <= '0;
         hang       <= 1'b0;
         hangCnt    <= '0;
         endPc      <= '0;
         for (int i = 0; i < NUM_CHECKS; i++) hitCnt[i] <= '0;
      end else begin
         fail_valid <= 1'b0;
         if (start && curState != RUN) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            seen_cnt <= '0;
            seenBits <= '0;
            hang     <= 1'b0;
            hangCnt  <= '0;
            endPc    <= end_pc;
            for (int i = 0; i < NUM_CHECKS; i++) hitCnt[i] <= '0;
         end else if (evalEn) begin
            hangCnt <= s1Same ? hangCnt + HW'(1) : '0;
            if (hangHit) hang <= 1'b1;
            if (hit) begin
               if (!seenBits[hitIdx]) begin
                  seenBits[hitIdx] <= 1'b1;
                  seen_cnt         <= seen_cnt + (IDX_W + 1)'(1);
               end
               if (hitKind == K_LOOP) hitCnt[hitIdx] <= hitNext;
            end
            if (isPass && pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_W'(1);
            if (isFail) begin
               if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_W'(1);
               fail_valid <= 1'b1;
               fail_idx   <= hitIdx;
            end
         end
      end
   end

   assign state = curState;

endmodule

// File: doc/riscv_retire_checker.md
# riscv_retire_checker

Synthesizable, parametrised retirement checker for the single-cycle RISC-V core. It watches the core's retirement signals (PC, Result, MemWrite, DataAdr, WriteData) each cycle and matches the PC against a run-time programmable table of checkpoints. It compares register results and store address/data against expected values, and bounds loop iterations. It reports pass/fail counts, a per-failure event, and hang/stuck detection. It sits beside riscv_cpu_main in simulation and in FPGA self-test builds, replacing hard-coded PC/value checks.

## Interface
- XLEN, 32, datapath width of monitored signals
- NUM_CHECKS, 64, checkpoint table depth (power of two)
- IDX_W, 6, log2(NUM_CHECKS)
- CNT_W, 16, width of pass/fail/hit counters (saturating)
- HANG_CYCLES, 256, consecutive cycles with unchanged PC that flag a hang

- clk  in  1  core clock
- reset  in  1  synchronous, active-high; clears all state except the checkpoint table
- cfg_we  in  1  write one table entry (honoured in IDLE only)
- cfg_idx  in  IDX_W  entry index
- cfg_kind  in  2  0=disabled, 1=result, 2=store, 3=loop-bound
- cfg_pc  in  XLEN  PC that triggers the entry
- cfg_data  in  XLEN  expected Result / WriteData; loop-bound: max unsigned Result
- cfg_mask  in  XLEN  bit mask applied to both sides of the data compare
- cfg_adr  in  XLEN  expected DataAdr (store kind); loop-bound: max hit count (low CNT_W bits)
- start  in  1  arm checker; clears counters and seen bits
- end_pc  in  XLEN  PC that terminates a run (sampled at start)
- PC, Result, DataAdr, WriteData  in  XLEN  core retirement signals
- MemWrite  in  1  core store strobe
- state  out  2  0=IDLE, 1=RUN, 2=DONE, 3=STUCK
- pass_cnt, fail_cnt  out  CNT_W  evaluation counters
- seen_cnt  out  IDX_W+1  distinct enabled entries hit at least once
- fail_valid  out  1  one-cycle pulse per failed evaluation
- fail_idx  out  IDX_W  index of failing entry (valid with fail_valid)
- hang  out  1  sticky; PC unchanged HANG_CYCLES cycles

## Operation
- The table is written only in IDLE. cfg_we in other states is ignored. The table is not cleared by reset, and reading an unwritten entry must behave as kind=0 after the first reset. Implement with a valid bit per entry, cleared on the first reset after power-up and never cleared again.
- FSM:
  - IDLE→RUN on start (end_pc latched). cfg_we and start in the same cycle: the write lands, then arm.
  - RUN→DONE when the registered PC equals latched end_pc.
  - RUN→STUCK on loop-bound violation or hang.
  - DONE/STUCK→RUN on start (counters, seen bits and hang cleared).
  - Reset→IDLE from any state.
- Match: all enabled entries are compared against the registered PC. If several entries match, the lowest index wins. No match means no action.
- Result kind: pass iff (Result & mask) == (data & mask).
- Store kind: pass iff MemWrite=1, DataAdr==adr, and (WriteData & mask)==(data & mask). MemWrite=0 at the PC is a fail.
- Loop-bound kind: per-entry hit counter increments on each hit. A violation occurs if Result > data (unsigned) or hit count > adr. A violation counts as a fail and enters STUCK. A non-violating hit adds nothing to pass_cnt.
- Every result/store hit is evaluated and counted. The entry's seen bit is set on its first hit of any kind.
- Counters saturate at all-ones. Nothing is evaluated outside RUN.
- Hang: counts cycles where PC equals the previous PC, and resets the count on any change. Reaching HANG_CYCLES sets hang and enters STUCK.

## Timing
- Stage 1: monitor inputs are registered at the clk rising edge.
- Stage 2: match, compare, and update counters/state. Outputs reflect a retirement 2 cycles after it is presented.
- fail_valid and fail_idx are registered and asserted for exactly 1 cycle per failure.
- State changes are visible 1 cycle after the deciding evaluation. The evaluation that causes DONE/STUCK is itself still counted.
- Reset values: state=IDLE, pass_cnt=fail_cnt=seen_cnt=0, fail_valid=0, fail_idx=0, hang=0, pipeline registers 0.
- Reset during RUN: the in-flight stage-1 sample is discarded and nothing is counted that cycle.
- start in RUN is ignored.

## Test plan
- Program entry 0 {result, pc=0x10, data=9, mask=all-ones}, start, drive PC=0x10 with Result=9 → pass_cnt=1, seen_cnt=1, 2-cycle latency.
- Entry 3 {store, pc=0x64, adr=33, data=1, mask=0xFF}. Drive MemWrite=1, DataAdr=33, WriteData=0x101 → pass. Repeat with MemWrite=0 → fail_valid pulse, fail_idx=3.
- Loop-bound entry {pc=0x90, data=0xA, adr=5}. Six hits with Result≤0xA → STUCK on the 6th hit, fail_cnt=1. Separately, Result=0xB on the first hit → STUCK.
- Entries 2 and 7 both at pc=0x34 with different data → only entry 2 is evaluated. end_pc=0x128 reached → DONE. start again → counters cleared, table retained.
- Hold PC constant for 256 cycles with HANG_CYCLES=256 → hang=1, STUCK. Reset mid-RUN → IDLE, all counters 0, table intact.
